// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic-computing datapath blocks.
package stoch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } stoch_state_e;

    // Signed weight of one bipolar (up,un) sample pair: +1, -1 or 0.
    function automatic logic signed [1:0] stoch_contrib(input logic up, input logic un);
        logic signed [1:0] c;
        c = 2'sd0;
        if (up && !un) begin
            c = 2'sd1;
        end else if (!up && un) begin
            c = -2'sd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/stoch_signed_bin_conv.sv
// Converts a two-rail signed stochastic stream into a signed binary sum
// over fixed windows of 2^WIN_LOG2 samples, with a valid/ready result port.
module stoch_signed_bin_conv
    import stoch_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = WIN_LOG2 + 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             up,
    input  logic             un,
    output logic [OUT_W-1:0] result,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    stoch_state_e            state_q, state_d;
    logic [OUT_W-1:0]        acc_q, acc_d;
    logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]        result_q, result_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic signed [OUT_W-1:0] step_s;
    logic [OUT_W-1:0]        sum;

    always_comb begin
        step_s    = OUT_W'(stoch_contrib(up, un));
        sum       = acc_q + step_s;
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '1) begin
                    // A completing window wins over consumption; an unread
                    // result being replaced is flagged as overrun.
                    result_d  = sum;
                    valid_d   = 1'b1;
                    overrun_d = valid_q && !ready;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign result  = result_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_stoch_signed_bin_conv.sv
// Scoreboard bench: a window-level reference model predicts outputs per cycle.
module tb_stoch_signed_bin_conv;

    localparam int WL = 4;
    localparam int N  = 16;
    localparam int OW = WL + 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          en = 1'b0;
    logic          up = 1'b0;
    logic          un = 1'b0;
    logic          ready = 1'b0;
    logic [OW-1:0] result;
    logic          valid;
    logic          overrun;

    always #5 CLK = ~CLK;

    stoch_signed_bin_conv #(.WIN_LOG2(WL), .OUT_W(OW)) dut (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .un(un),
        .result(result), .valid(valid), .ready(ready), .overrun(overrun)
    );

    typedef struct {
        bit valid;
        bit ov;
        int res;
        int tag;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   stepno = 0;

    // Reference model: a window is simply the list of sample weights seen so far.
    bit   m_active = 0;
    int   m_win[$];
    bit   m_valid = 0;
    bit   m_ov = 0;
    int   m_res = 0;

    task automatic step(input bit r, input bit e, input bit u, input bit n, input bit rd);
        exp_t x;
        bit   fresh;
        int   s;
        @(negedge CLK);
        RST = r; en = e; up = u; un = n; ready = rd;
        stepno++;
        fresh = 0;
        s = 0;
        if (r) begin
            m_active = 0; m_win.delete(); m_valid = 0; m_ov = 0; m_res = 0;
        end else begin
            m_ov = 0;
            if (!m_active) begin
                if (e) begin
                    m_active = 1;
                    m_win.delete();
                end
            end else if (!e) begin
                m_active = 0;
                m_win.delete();
            end else begin
                m_win.push_back((u && !n) ? 1 : ((!u && n) ? -1 : 0));
                if (m_win.size() == N) begin
                    s = m_win.sum();
                    fresh = 1;
                    m_win.delete();
                end
            end
            if (fresh) begin
                m_ov = m_valid && !rd;
                m_res = s;
                m_valid = 1;
            end else if (m_valid && rd) begin
                m_valid = 0;
            end
        end
        x.valid = m_valid; x.ov = m_ov; x.res = m_res; x.tag = stepno;
        expq.push_back(x);
    endtask

    task automatic window(input int npos, input int nneg, input int nboth, input bit rd_last, input bit rd);
        for (int i = 0; i < N; i++) begin
            if (i < npos) step(0, 1, 1, 0, (i == N - 1) ? rd_last : rd);
            else if (i < npos + nneg) step(0, 1, 0, 1, (i == N - 1) ? rd_last : rd);
            else if (i < npos + nneg + nboth) step(0, 1, 1, 1, (i == N - 1) ? rd_last : rd);
            else step(0, 1, 0, 0, (i == N - 1) ? rd_last : rd);
        end
    endtask

    // Monitor: compares every predicted cycle just after the active edge.
    exp_t mx;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                mx = expq.pop_front();
                total++;
                if (valid !== mx.valid || overrun !== mx.ov || int'($signed(result)) !== mx.res) begin
                    bad++;
                    $display("FAIL step%0d: got valid=%b result=%0d overrun=%b, need valid=%b result=%0d overrun=%b",
                             mx.tag, valid, $signed(result), overrun, mx.valid, mx.res, mx.ov);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        // all-positive window, consumed immediately
        step(0, 1, 0, 0, 1);
        window(16, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // mixed window to -8, then back-to-back second window
        step(0, 1, 0, 0, 1);
        window(0, 8, 8, 1, 1);
        window(3, 0, 5, 1, 1);
        // full negative window at the range boundary
        window(0, 16, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        // two windows unread: overrun on the second, then consume
        step(0, 1, 0, 0, 0);
        window(4, 0, 3, 0, 0);
        window(0, 2, 6, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // abort after 10 samples, then a clean window
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        window(16, 0, 0, 1, 1);
        // reset mid-window while a result is held
        window(5, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        window(9, 2, 0, 0, 0);
        // consume at the same edge a new window completes
        window(1, 6, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
        end
        step(0, 0, 0, 0, 1);
        repeat (3) @(posedge CLK);
        #2;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, need 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
